// File: rtl/hdmi_sched_pkg.sv
// Shared types and constants for the HDMI processing-mode scheduler.
package hdmi_sched_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned MUTE_CNT_W  = 4;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GRAY   = 2'd1;
  localparam logic [1:0] MODE_BIN    = 2'd2;
  localparam logic [1:0] MODE_EDGE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PENDING = 3'd3,
    ST_MUTE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/vs_edge_det.sv
// Vertical-sync activation detector: one-flop history, polarity-aware.
module vs_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic pixclk_in,
  input  logic rst_n,
  input  logic vs_in,
  output logic vs_rise_c
);

  logic vs_act_c;
  logic vs_act_q;

  assign vs_act_c = (vs_in == VS_POL);

  // History holds "was active", so reset means inactive regardless of polarity.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) vs_act_q <= 1'b0;
    else        vs_act_q <= vs_act_c;
  end

  assign vs_rise_c = vs_act_c & ~vs_act_q;

endmodule

// File: rtl/hdmi_proc_sched.sv
// Frame-synchronous mode scheduler for the HDMI pixel chain (mux select + mute).
// Optional frame counter enabled by defining HDMI_SCHED_FRAME_CNT_EN.
module hdmi_proc_sched
  import hdmi_sched_pkg::*;
#(
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned MUTE_FRAMES = 2,
  parameter bit          VS_POL      = 1'b1
) (
  input  logic                   pixclk_in,
  input  logic                   rst_n,
  input  logic                   init_over,
  input  logic                   vs_in,
  input  logic                   req_valid,
  input  logic [MODE_W-1:0]      req_mode,
  output logic                   req_ready,
  output logic                   req_done,
  output logic [MODE_W-1:0]      sel_out,
  output logic                   mute,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  sched_state_t          state_q, state_nxt;
  logic [MODE_W-1:0]     pend_mode_q, pend_mode_nxt;
  logic [MODE_W-1:0]     sel_nxt;
  logic [MUTE_CNT_W-1:0] mute_cnt_q, mute_cnt_nxt;
  logic                  mute_nxt;
  logic                  ready_nxt;
  logic                  done_nxt;
  logic                  vs_rise_c;

  vs_edge_det #(.VS_POL(VS_POL)) u_vs_edge_det (
    .pixclk_in (pixclk_in),
    .rst_n     (rst_n),
    .vs_in     (vs_in),
    .vs_rise_c (vs_rise_c)
  );

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_mode_q <= MODE_W'(MODE_BYPASS);
      sel_out     <= MODE_W'(MODE_BYPASS);
      mute_cnt_q  <= '0;
      mute        <= 1'b1;
      req_ready   <= 1'b0;
      req_done    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pend_mode_q <= pend_mode_nxt;
      sel_out     <= sel_nxt;
      mute_cnt_q  <= mute_cnt_nxt;
      mute        <= mute_nxt;
      req_ready   <= ready_nxt;
      req_done    <= done_nxt;
    end
  end

  // Loss of init overrides every state: mute, drop any pending request, keep sel_out.
  always_comb begin
    state_nxt     = state_q;
    pend_mode_nxt = pend_mode_q;
    sel_nxt       = sel_out;
    mute_cnt_nxt  = mute_cnt_q;
    mute_nxt      = mute;
    done_nxt      = 1'b0;

    if (!init_over) begin
      state_nxt    = ST_IDLE;
      mute_nxt     = 1'b1;
      mute_cnt_nxt = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_ALIGN;
        ST_ALIGN: begin
          if (vs_rise_c) begin
            state_nxt = ST_RUN;
            mute_nxt  = 1'b0;
          end
        end
        ST_RUN: begin
          if (req_valid && req_ready) begin
            pend_mode_nxt = req_mode;
            if (req_mode == sel_out) done_nxt  = 1'b1;
            else                     state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (vs_rise_c) begin
            sel_nxt = pend_mode_q;
            if (MUTE_FRAMES != 0) begin
              mute_nxt     = 1'b1;
              mute_cnt_nxt = MUTE_CNT_W'(MUTE_FRAMES);
              state_nxt    = ST_MUTE;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = ST_RUN;
            end
          end
        end
        ST_MUTE: begin
          if (vs_rise_c) begin
            if (mute_cnt_q == MUTE_CNT_W'(1)) begin
              mute_nxt     = 1'b0;
              done_nxt     = 1'b1;
              mute_cnt_nxt = '0;
              state_nxt    = ST_RUN;
            end else begin
              mute_cnt_nxt = mute_cnt_q - MUTE_CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    ready_nxt = (state_nxt == ST_RUN);
  end

`ifdef HDMI_SCHED_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Counts frames outside IDLE; cleared on the same edge that enters IDLE.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n)                            frame_cnt_q <= '0;
    else if (!init_over)                   frame_cnt_q <= '0;
    else if (state_q != ST_IDLE && vs_rise_c) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_proc_sched.sv
// Directed bench: u0 mutes 2 frames on active-high vsync, u1 switches unmuted on active-low vsync.
module tb_hdmi_proc_sched;
  import hdmi_sched_pkg::*;

  localparam int unsigned MODE_W = 2;

  logic pixclk_in = 1'b0;
  always #5 pixclk_in = ~pixclk_in;

  logic              rst_n, init_over, vs0, vs1;
  logic              req_valid, req_valid1;
  logic [MODE_W-1:0] req_mode, req_mode1;
  logic              req_ready, req_done, mute;
  logic              req_ready1, req_done1, mute1;
  logic [MODE_W-1:0] sel_out, sel_out1;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt1;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  assign vs1 = ~vs0;

  hdmi_proc_sched #(.MODE_W(MODE_W), .MUTE_FRAMES(2), .VS_POL(1'b1)) u0 (
    .pixclk_in (pixclk_in), .rst_n (rst_n), .init_over (init_over), .vs_in (vs0),
    .req_valid (req_valid), .req_mode (req_mode), .req_ready (req_ready),
    .req_done (req_done), .sel_out (sel_out), .mute (mute), .frame_cnt (frame_cnt)
  );

  hdmi_proc_sched #(.MODE_W(MODE_W), .MUTE_FRAMES(0), .VS_POL(1'b0)) u1 (
    .pixclk_in (pixclk_in), .rst_n (rst_n), .init_over (init_over), .vs_in (vs1),
    .req_valid (req_valid1), .req_mode (req_mode1), .req_ready (req_ready1),
    .req_done (req_done1), .sel_out (sel_out1), .mute (mute1), .frame_cnt (frame_cnt1)
  );

  task automatic step();
    @(posedge pixclk_in);
    #1;
  endtask

  task automatic rise();
    vs0 = 1'b1;
    step();
  endtask

  task automatic settle();
    step();
    step();
    vs0 = 1'b0;
    step();
    step();
    step();
  endtask

  function automatic logic [31:0] fce(input int n);
`ifdef HDMI_SCHED_FRAME_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; init_over = 1'b0; vs0 = 1'b0;
    req_valid = 1'b0; req_mode = MODE_BYPASS;
    req_valid1 = 1'b0; req_mode1 = MODE_BYPASS;
    step(); step();
    chk("rst_sel",   32'(sel_out),   0);
    chk("rst_mute",  32'(mute),      1);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done",  32'(req_done),  0);
    chk("rst_fcnt",  32'(frame_cnt), 0);

    rst_n = 1'b1;
    repeat (9) step();
    chk("idle_mute",  32'(mute),      1);
    chk("idle_ready", 32'(req_ready), 0);

    init_over = 1'b1;
    step();
    chk("align_ready", 32'(req_ready), 0);
    chk("align_mute",  32'(mute),      1);
    repeat (38) step();
    chk("pre_vs_mute", 32'(mute), 1);

    // First active vsync leaves ALIGN
    rise();
    chk("run_mute",   32'(mute),      0);
    chk("run_ready",  32'(req_ready), 1);
    chk("run_sel",    32'(sel_out),   0);
    chk("run_fcnt",   32'(frame_cnt), fce(1));
    chk("run_mute1",  32'(mute1),     0);
    chk("run_ready1", 32'(req_ready1), 1);
    settle();
    chk("vs_level_fcnt", 32'(frame_cnt), fce(1));

    // Switch to GRAY; valid stays high with BIN while pending
    req_valid = 1'b1; req_mode = MODE_GRAY;
    step();
    chk("acc_ready", 32'(req_ready), 0);
    chk("acc_sel",   32'(sel_out),   0);
    chk("acc_mute",  32'(mute),      0);
    chk("acc_done",  32'(req_done),  0);
    req_mode = MODE_BIN;
    step(); step();
    chk("pend_ready", 32'(req_ready), 0);
    chk("pend_sel",   32'(sel_out),   0);
    rise();
    chk("sw_sel",  32'(sel_out),   1);
    chk("sw_mute", 32'(mute),      1);
    chk("sw_done", 32'(req_done),  0);
    chk("sw_fcnt", 32'(frame_cnt), fce(2));
    req_valid = 1'b0;
    settle();
    rise();
    chk("m1_mute",  32'(mute),      1);
    chk("m1_done",  32'(req_done),  0);
    chk("m1_ready", 32'(req_ready), 0);
    settle();
    rise();
    chk("m2_mute",  32'(mute),      0);
    chk("m2_done",  32'(req_done),  1);
    chk("m2_ready", 32'(req_ready), 1);
    chk("m2_sel",   32'(sel_out),   1);
    chk("m2_fcnt",  32'(frame_cnt), fce(4));
    step();
    chk("m2_done_off", 32'(req_done), 0);
    chk("u1_sel_idle", 32'(sel_out1), 0);
    settle();

    // Same-mode request completes without a frame wait
    req_valid = 1'b1; req_mode = MODE_GRAY;
    step();
    chk("same_done",  32'(req_done),  1);
    chk("same_ready", 32'(req_ready), 1);
    chk("same_mute",  32'(mute),      0);
    req_valid = 1'b0;
    step();
    chk("same_done_off", 32'(req_done), 0);
    chk("same_sel",      32'(sel_out),  1);

    // u1 pending on EDGE; u0 accepts BIN on the same edge as the vsync
    req_valid1 = 1'b1; req_mode1 = MODE_EDGE;
    step();
    chk("u1_acc_ready", 32'(req_ready1), 0);
    req_valid1 = 1'b0;
    req_valid = 1'b1; req_mode = MODE_BIN;
    rise();
    req_valid = 1'b0;
    chk("coinc_ready", 32'(req_ready),  0);
    chk("coinc_sel",   32'(sel_out),    1);
    chk("coinc_mute",  32'(mute),       0);
    chk("coinc_fcnt",  32'(frame_cnt),  fce(5));
    chk("u1_sel",      32'(sel_out1),   3);
    chk("u1_done",     32'(req_done1),  1);
    chk("u1_mute",     32'(mute1),      0);
    chk("u1_ready",    32'(req_ready1), 1);
    step();
    chk("u1_done_off", 32'(req_done1), 0);
    settle();
    rise();
    chk("coinc_sw_sel",  32'(sel_out), 2);
    chk("coinc_sw_mute", 32'(mute),    1);
    settle();

    // Init loss while muting
    init_over = 1'b0;
    step();
    chk("drop_mute",   32'(mute),       1);
    chk("drop_ready",  32'(req_ready),  0);
    chk("drop_done",   32'(req_done),   0);
    chk("drop_sel",    32'(sel_out),    2);
    chk("drop_fcnt",   32'(frame_cnt),  0);
    chk("drop_mute1",  32'(mute1),      1);
    chk("drop_sel1",   32'(sel_out1),   3);
    step(); step();
    rise();
    chk("idle_vs_fcnt", 32'(frame_cnt), 0);
    chk("idle_vs_mute", 32'(mute),      1);
    chk("idle_vs_done", 32'(req_done),  0);
    settle();

    init_over = 1'b1;
    step();
    chk("re_align_ready", 32'(req_ready), 0);
    chk("re_align_mute",  32'(mute),      1);
    step(); step();
    rise();
    chk("re_run_mute",  32'(mute),       0);
    chk("re_run_ready", 32'(req_ready),  1);
    chk("re_run_sel",   32'(sel_out),    2);
    chk("re_run_done",  32'(req_done),   0);
    chk("re_run_fcnt",  32'(frame_cnt),  fce(1));
    chk("re_run_mute1", 32'(mute1),      0);
    chk("re_run_fcnt1", 32'(frame_cnt1), fce(1));
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
